// File: rtl/ddr2_wr_stream_feeder.sv
// ddr2_wr_stream_feeder
// Buffers a 16-bit valid/ready stream in a first-word-fall-through FIFO and
// hands it to axi_wr_master one burst at a time. A request is only raised
// once a full burst is already buffered, so the consumer never stalls on data.
// The write address walks a circular region, advancing by one burst per wr_done.
module ddr2_wr_stream_feeder #(
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH  = 128,
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned REGION_SIZE = 1 << 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_end,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic                           wr_trig,
    output logic [7:0]                     wr_len,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           wr_data_en,
    input  logic                           wr_ready,
    input  logic                           wr_done,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [15:0]                    burst_cnt,
    output logic                           underflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // Address arithmetic is one bit wider so the end-of-region compare
    // cannot be fooled by a carry out of the top address bit.
    localparam logic [ADDR_WIDTH:0]   ADDR_STEP  = (ADDR_WIDTH+1)'(2 * BURST_LEN);
    localparam logic [ADDR_WIDTH:0]   REGION_END = (ADDR_WIDTH+1)'(BASE_ADDR + REGION_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [LVL_W-1:0]      LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]      LVL_BURST  = LVL_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [LVL_W-1:0]      level_reg;
    logic                  underflow_reg;
    logic                  push;
    logic                  pop;

    // Burst sequencing
    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [15:0]           cnt_reg;
    logic [15:0]           cnt_next;
    logic [ADDR_WIDTH:0]   addr_sum;

    // Readiness looks only at the registered level: a pop in the same cycle
    // does not free a slot until the following cycle.
    assign s_ready = (level_reg != LVL_FULL);
    assign push    = s_valid & s_ready;
    assign pop     = wr_data_en & (level_reg != '0);

    // Head word is read asynchronously so a word written into an empty FIFO
    // is visible the cycle right after it was pushed.
    assign wr_data    = mem_reg[rd_ptr_reg];
    assign fifo_level = level_reg;
    assign underflow  = underflow_reg;
    assign wr_len     = 8'(BURST_LEN);
    assign wr_addr    = addr_reg;
    assign burst_cnt  = cnt_reg;

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= s_data;
        end
    end

    // Pointer and level tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky flag for a pop attempted against an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_reg <= 1'b0;
        end else if (wr_data_en && (level_reg == '0)) begin
            underflow_reg <= 1'b1;
        end
    end

    // Sequencer state, address and completed-burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= BASE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: request only with a full burst buffered, and only
    // advance the address once the downstream burst has completed.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        wr_trig    = 1'b0;
        addr_sum   = {1'b0, addr_reg} + ADDR_STEP;

        case (state_reg)
            ST_IDLE: begin
                if (init_end && (level_reg >= LVL_BURST)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                wr_trig = 1'b1;
                if (wr_ready) begin
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (wr_done) begin
                    if (addr_sum >= REGION_END) begin
                        addr_next = BASE;
                    end else begin
                        addr_next = addr_sum[ADDR_WIDTH-1:0];
                    end
                    cnt_next   = cnt_reg + 16'd1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr2_wr_stream_feeder.sv
// tb_ddr2_wr_stream_feeder
// Random stimulus against a queue-based reference: the FIFO is a queue, the
// burst address is derived from the number of completed bursts.
module tb_ddr2_wr_stream_feeder;

    localparam int AW     = 27;
    localparam int DW     = 16;
    localparam int DEPTH  = 128;
    localparam int BL     = 32;
    localparam int BASE   = 1024;
    localparam int REGION = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_end;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          wr_trig;
    logic [7:0]    wr_len;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_data_en;
    logic          wr_ready;
    logic          wr_done;
    logic [7:0]    fifo_level;
    logic [15:0]   burst_cnt;
    logic          underflow;

    ddr2_wr_stream_feeder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .BURST_LEN   (BL),
        .BASE_ADDR   (BASE),
        .REGION_SIZE (REGION)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_end   (init_end),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wr_trig    (wr_trig),
        .wr_len     (wr_len),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_data_en (wr_data_en),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .fifo_level (fifo_level),
        .burst_cnt  (burst_cnt),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: buffered words, burst phase (0 idle, 1 requesting,
    // 2 transferring), completed bursts since reset, sticky underflow.
    logic [DW-1:0] m_q[$];
    int            m_phase;
    int            m_cnt;
    bit            m_uflow;
    int            n_bursts;
    bit            did_rst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("level",     64'(fifo_level), 64'(m_q.size()));
        chk("s_ready",   64'(s_ready),    64'(m_q.size() != DEPTH));
        chk("wr_trig",   64'(wr_trig),    64'(m_phase == 1));
        chk("wr_addr",   64'(wr_addr),    64'(BASE + (m_cnt * 2 * BL) % REGION));
        chk("burst_cnt", 64'(burst_cnt),  64'(m_cnt & 16'hFFFF));
        chk("underflow", 64'(underflow),  64'(m_uflow));
        if (m_q.size() > 0) begin
            chk("wr_data", 64'(wr_data), 64'(m_q[0]));
        end
    endtask

    // Apply the current inputs to the reference, clock the DUT, then compare
    // on the falling edge.
    task automatic step();
        int lvl;
        bit push;
        bit pop;
        lvl = m_q.size();
        if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_cnt   = 0;
            m_uflow = 0;
        end else begin
            push = s_valid && (lvl != DEPTH);
            pop  = wr_data_en && (lvl != 0);
            if (wr_data_en && lvl == 0) m_uflow = 1;
            case (m_phase)
                0: if (init_end && lvl >= BL) m_phase = 1;
                1: if (wr_ready) m_phase = 2;
                2: if (wr_done) begin
                       m_cnt++;
                       n_bursts++;
                       m_phase = 0;
                   end
                default: m_phase = 0;
            endcase
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(s_data);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst        = 1'b1;
        init_end   = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        wr_data_en = 1'b0;
        wr_ready   = 1'b0;
        wr_done    = 1'b0;
        m_phase    = 0;
        m_cnt      = 0;
        m_uflow    = 0;
        n_bursts   = 0;
        did_rst    = 0;

        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("wr_len", 64'(wr_len), 64'(BL));

        // Pop while empty: underflow sets, level stays zero; then clear by reset.
        wr_data_en = 1'b1;
        step();
        wr_data_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Fill to full with init low: no request, s_ready drops at full.
        s_valid = 1'b1;
        for (int i = 0; i < 140; i++) begin
            s_data = DW'($urandom);
            step();
        end
        // Push and pop together at full, then again at 127.
        wr_data_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = DW'($urandom);
            step();
        end
        wr_data_en = 1'b0;
        s_valid    = 1'b0;
        step();

        // Random traffic with init high; a window with init low; one reset
        // taken mid-transfer.
        init_end = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst        = 1'b0;
            init_end   = !(i >= 2500 && i < 2700);
            s_valid    = ($urandom_range(0, 1) == 1);
            s_data     = DW'($urandom);
            wr_data_en = ($urandom_range(0, 99) < 35);
            wr_ready   = ($urandom_range(0, 3) == 0);
            wr_done    = ($urandom_range(0, 7) == 0);
            if (i > 1500 && !did_rst && m_phase == 2) begin
                rst     = 1'b1;
                did_rst = 1;
            end
            step();
        end
        rst        = 1'b0;
        s_valid    = 1'b0;
        wr_data_en = 1'b0;
        wr_done    = 1'b0;
        step();

        // The run must have exercised wrap-around and the mid-burst reset.
        chk("bursts_seen", 64'(n_bursts >= 5), 64'(1));
        chk("reset_seen",  64'(did_rst), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
